// File: rtl/stepper_seq_ctrl.sv
// Unipolar stepper sequencer: wave/full/half-step phase generation with a
// counted move, start/busy/done handshake, abort and optional idle hold.
module stepper_seq_ctrl #(
  parameter int BASE_DIV = 1000,
  parameter int SPD_W    = 4,
  parameter int CNT_W    = 16,
  parameter bit HOLD     = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [SPD_W-1:0] speed,
  input  logic [CNT_W-1:0] steps,
  output logic [3:0]       out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remain
);

  localparam int PW = $clog2((2 ** SPD_W) * BASE_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       ph_reg, ph_next;
  logic [CNT_W-1:0] remain_reg, remain_next;
  logic [PW-1:0]    cnt_reg, cnt_next;
  logic [PW-1:0]    term_reg, term_next;
  logic             dir_reg, dir_next;
  logic             half_reg, half_next;
  logic             done_reg, done_next;

  logic [SPD_W:0]   speed_p1;
  logic [PW-1:0]    term_calc;
  logic [2:0]       ph_inc;
  logic             misalign;

  function automatic logic [3:0] pattern(input logic [2:0] p);
    case (p)
      3'd0:    pattern = 4'b1000;
      3'd1:    pattern = 4'b1100;
      3'd2:    pattern = 4'b0100;
      3'd3:    pattern = 4'b0110;
      3'd4:    pattern = 4'b0010;
      3'd5:    pattern = 4'b0011;
      3'd6:    pattern = 4'b0001;
      default: pattern = 4'b1001;
    endcase
  endfunction

  // speed+1 is formed one bit wider so an all-ones speed cannot wrap to zero
  always_comb begin
    speed_p1  = {1'b0, speed} + {{SPD_W{1'b0}}, 1'b1};
    term_calc = PW'(32'(speed_p1) * 32'(BASE_DIV) - 32'd1);
    ph_inc    = half_reg ? 3'd1 : 3'd2;
    // wave lives on even phases, full (and reserved) on odd, half anywhere
    case (mode)
      2'b00:   misalign = ph_reg[0];
      2'b10:   misalign = 1'b0;
      default: misalign = ~ph_reg[0];
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    ph_next     = ph_reg;
    remain_next = remain_reg;
    cnt_next    = cnt_reg;
    term_next   = term_reg;
    dir_next    = dir_reg;
    half_next   = half_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (steps != '0) begin
            state_next  = RUN;
            dir_next    = dir;
            half_next   = (mode == 2'b10);
            term_next   = term_calc;
            remain_next = steps;
            cnt_next    = '0;
            if (misalign) ph_next = dir ? ph_reg + 3'd1 : ph_reg - 3'd1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (cnt_reg == term_reg) begin
          cnt_next    = '0;
          ph_next     = dir_reg ? ph_reg + ph_inc : ph_reg - ph_inc;
          remain_next = remain_reg - CNT_W'(1);
          if (remain_reg == CNT_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + PW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      ph_reg     <= 3'd0;
      remain_reg <= '0;
      cnt_reg    <= '0;
      term_reg   <= '0;
      dir_reg    <= 1'b0;
      half_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ph_reg     <= ph_next;
      remain_reg <= remain_next;
      cnt_reg    <= cnt_next;
      term_reg   <= term_next;
      dir_reg    <= dir_next;
      half_reg   <= half_next;
      done_reg   <= done_next;
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = done_reg;
  assign remain = remain_reg;
  assign out    = (busy || HOLD) ? pattern(ph_reg) : 4'b0000;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Bench for stepper_seq_ctrl: a HOLD=1 and a HOLD=0 instance share stimulus;
// a directed vector table plus randomized traffic against a timing model.
module tb_stepper_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, stop, dir;
  logic [1:0]  mode;
  logic [3:0]  speed;
  logic [15:0] steps;

  logic [3:0]  out_h, out_z;
  logic        busy_h, busy_z, done_h, done_z;
  logic [15:0] remain_h, remain_z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stepper_seq_ctrl #(.BASE_DIV(4), .SPD_W(4), .CNT_W(16), .HOLD(1'b1)) dut_h (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .dir(dir),
    .mode(mode), .speed(speed), .steps(steps),
    .out(out_h), .busy(busy_h), .done(done_h), .remain(remain_h)
  );

  stepper_seq_ctrl #(.BASE_DIV(4), .SPD_W(4), .CNT_W(16), .HOLD(1'b0)) dut_z (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .dir(dir),
    .mode(mode), .speed(speed), .steps(steps),
    .out(out_z), .busy(busy_z), .done(done_z), .remain(remain_z)
  );

  // Reference model: position is derived from elapsed time since accept.
  logic [3:0] pat [8];
  int  t_now = 0;
  bit  m_busy, m_done;
  int  m_ph, m_ph0, m_rem, m_n, m_p, m_inc, m_t0;
  bit  m_accepted;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_ph = 0; m_rem = 0;
  endtask

  task automatic model_step();
    int taken, stp;
    t_now++;
    m_done = 0;
    m_accepted = 0;
    if (m_busy) begin
      if (stop) begin
        m_busy = 0;
      end else begin
        taken = (t_now - m_t0) / m_p;
        m_ph  = (((m_ph0 + m_inc * taken) % 8) + 8) % 8;
        m_rem = m_n - taken;
        if (taken == m_n) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (start) begin
      if (steps != 0) begin
        stp = (mode == 2'b10) ? 1 : 2;
        if ((mode == 2'b00 && (m_ph % 2) == 1) ||
            (mode != 2'b00 && mode != 2'b10 && (m_ph % 2) == 0))
          m_ph = (m_ph + (dir ? 1 : 7)) % 8;
        m_ph0  = m_ph;
        m_inc  = dir ? stp : -stp;
        m_t0   = t_now;
        m_p    = (int'(speed) + 1) * 4;
        m_n    = int'(steps);
        m_rem  = m_n;
        m_busy = 1;
        m_accepted = 1;
      end else begin
        m_done = 1;
      end
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, " out_h"}, 32'(out_h), 32'(pat[m_ph]));
    check({tag, " out_z"}, 32'(out_z), m_busy ? 32'(pat[m_ph]) : 32'd0);
    check({tag, " busy"}, {30'd0, busy_h, busy_z}, {30'd0, m_busy, m_busy});
    check({tag, " done"}, {30'd0, done_h, done_z}, {30'd0, m_done, m_done});
    check({tag, " remain"}, {remain_h, remain_z}, {16'(m_rem), 16'(m_rem)});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    model_check($sformatf("t%0d", t_now));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    model_check("reset");
    #2;
    rstn = 1'b1;
  endtask

  typedef struct {
    bit        rst;
    bit        start;
    bit        stop;
    bit        dir;
    bit [1:0]  mode;
    bit [3:0]  speed;
    bit [15:0] steps;
    int        cyc;
    bit [3:0]  e_out;
    bit        e_busy;
    bit        e_done;
    bit [15:0] e_rem;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit s, input bit sp, input bit d, input bit [1:0] m,
                     input bit [3:0] spd, input bit [15:0] n, input int c,
                     input bit [3:0] eo, input bit eb, input bit ed, input bit [15:0] er);
    vec_t v;
    v.rst = r; v.start = s; v.stop = sp; v.dir = d; v.mode = m; v.speed = spd;
    v.steps = n; v.cyc = c; v.e_out = eo; v.e_busy = eb; v.e_done = ed; v.e_rem = er;
    vt.push_back(v);
  endtask

  initial begin
    pat = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};

    // rst start stop dir mode speed steps cyc | out busy done remain
    add(1,0,0,0,0, 0,  0, 0, 4'b1000,0,0,0);
    // half, forward, P=4, 3 steps
    add(0,1,0,1,2, 0,  3, 1, 4'b1000,1,0,3);
    add(0,0,0,1,2, 0,  3, 3, 4'b1000,1,0,3);
    add(0,0,0,1,2, 0,  3, 1, 4'b1100,1,0,2);
    add(0,0,0,1,2, 0,  3, 4, 4'b0100,1,0,1);
    add(0,0,0,1,2, 0,  3, 3, 4'b0100,1,0,1);
    add(0,0,0,1,2, 0,  3, 1, 4'b0110,0,1,0);
    add(0,0,0,1,2, 0,  3, 1, 4'b0110,0,0,0);
    // reset in the middle of a move
    add(0,1,0,1,1, 0,  7, 1, 4'b0110,1,0,7);
    add(0,0,0,1,1, 0,  7, 4, 4'b0011,1,0,6);
    add(1,0,0,0,0, 0,  0, 0, 4'b1000,0,0,0);
    // full, reverse, P=8, alignment 0->7, extra start mid-run ignored
    add(0,1,0,0,1, 1,  5, 1, 4'b1001,1,0,5);
    add(0,0,0,0,1, 1,  5, 7, 4'b1001,1,0,5);
    add(0,0,0,0,1, 1,  5, 1, 4'b0011,1,0,4);
    add(0,0,0,0,1, 1,  5, 8, 4'b0110,1,0,3);
    add(0,1,0,1,2, 3,100, 1, 4'b0110,1,0,3);
    add(0,0,0,1,2, 3,100, 7, 4'b1100,1,0,2);
    add(0,0,0,0,1, 1,  5, 8, 4'b1001,1,0,1);
    add(0,0,0,0,1, 1,  5, 7, 4'b1001,1,0,1);
    add(0,0,0,0,1, 1,  5, 1, 4'b0011,0,1,0);
    add(0,0,0,0,1, 1,  5, 1, 4'b0011,0,0,0);
    // zero-step start
    add(0,1,0,1,2, 0,  0, 1, 4'b0011,0,1,0);
    add(0,0,0,1,2, 0,  0, 1, 4'b0011,0,0,0);
    // wave, 4 steps, abort after step 2
    add(0,1,0,1,0, 0,  4, 1, 4'b0001,1,0,4);
    add(0,0,0,1,0, 0,  4, 4, 4'b1000,1,0,3);
    add(0,0,0,1,0, 0,  4, 4, 4'b0100,1,0,2);
    add(0,0,1,1,0, 0,  4, 1, 4'b0100,0,0,2);
    add(0,0,0,1,0, 0,  4, 2, 4'b0100,0,0,2);
    // stop coincident with terminal count
    add(0,1,0,1,0, 0,  2, 1, 4'b0100,1,0,2);
    add(0,0,0,1,0, 0,  2, 3, 4'b0100,1,0,2);
    add(0,0,1,1,0, 0,  2, 1, 4'b0100,0,0,2);
    // stop while idle
    add(0,0,1,0,0, 0,  0, 2, 4'b0100,0,0,2);
    // start held: back-to-back single-step moves
    add(0,1,0,0,2, 0,  1, 1, 4'b0100,1,0,1);
    add(0,1,0,0,2, 0,  1, 3, 4'b0100,1,0,1);
    add(0,1,0,0,2, 0,  1, 1, 4'b1100,0,1,0);
    add(0,1,0,0,2, 0,  1, 1, 4'b1100,1,0,1);
    add(0,1,0,0,2, 0,  1, 3, 4'b1100,1,0,1);
    add(0,1,0,0,2, 0,  1, 1, 4'b1000,0,1,0);
    add(0,0,0,0,2, 0,  1, 1, 4'b1000,0,0,0);
    // maximum speed select: P=64
    add(0,1,0,1,2,15,  2, 1, 4'b1000,1,0,2);
    add(0,0,0,1,2,15,  2,63, 4'b1000,1,0,2);
    add(0,0,0,1,2,15,  2, 1, 4'b1100,1,0,1);
    add(0,0,0,1,2,15,  2,63, 4'b1100,1,0,1);
    add(0,0,0,1,2,15,  2, 1, 4'b0100,0,1,0);

    rstn = 1'b0; start = 0; stop = 0; dir = 0; mode = 0; speed = 0; steps = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    foreach (vt[i]) begin
      start = vt[i].start; stop = vt[i].stop; dir = vt[i].dir;
      mode = vt[i].mode; speed = vt[i].speed; steps = vt[i].steps;
      if (vt[i].rst) do_reset();
      else repeat (vt[i].cyc) cycle();
      check($sformatf("row%0d out_h", i), 32'(out_h), 32'(vt[i].e_out));
      check($sformatf("row%0d out_z", i), 32'(out_z), vt[i].e_busy ? 32'(vt[i].e_out) : 32'd0);
      check($sformatf("row%0d busy", i), {30'd0, busy_h, busy_z}, {30'd0, vt[i].e_busy, vt[i].e_busy});
      check($sformatf("row%0d done", i), {30'd0, done_h, done_z}, {30'd0, vt[i].e_done, vt[i].e_done});
      check($sformatf("row%0d remain", i), {remain_h, remain_z}, {vt[i].e_rem, vt[i].e_rem});
      $display("row %0d: out=%b busy=%b done=%b remain=%0d", i, out_h, busy_h, done_h, remain_h);
    end

    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      dir   = 1'($urandom_range(0, 1));
      mode  = 2'($urandom_range(0, 3));
      speed = 4'($urandom_range(0, 3));
      steps = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
        $display("random t=%0d: reset", t_now);
      end else begin
        cycle();
        if (m_accepted)
          $display("random t=%0d: move dir=%0d mode=%0d speed=%0d steps=%0d ph=%0d",
                   t_now, dir, mode, speed, steps, m_ph);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stepper_seq_ctrl.md
# stepper_seq_ctrl

Parametrised unipolar stepper-motor sequencer, successor to the fixed 4-phase speed-select driver. It supports wave, full-step and half-step modes, moves a commanded number of steps with a start/busy/done handshake, and supports abort and idle coil de-energising. It sits between the control FSM or register interface and the coil driver transistors (L1..L4) of a 28BYJ-48-class motor.

## Interface
- BASE_DIV, 1000: clk cycles per speed unit; step period P = (speed+1)*BASE_DIV cycles (≥2).
- SPD_W, 4: width of speed input.
- CNT_W, 16: width of step-count input and remain output.
- HOLD, 1: 1 = coils stay energised on last pattern when idle; 0 = out=4'b0000 when idle.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  move request, sampled each cycle.
- stop  in  1  abort request, sampled each cycle.
- dir  in  1  1 = forward (phase index increments), 0 = reverse.
- mode  in  2  00 wave, 01 full (two-phase), 10 half, 11 reserved (treated as full).
- speed  in  SPD_W  step-rate select.
- steps  in  CNT_W  number of steps to move.
- out  out  4  coil drive L1L2L3L4.
- busy  out  1  move in progress.
- done  out  1  one-cycle pulse on normal completion.
- remain  out  CNT_W  steps still to take.

## Operation
- Phase index ph[2:0]. Half-step table: 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001. Index wraps modulo 8 in both directions.
- Wave mode uses even ph only; full mode uses odd ph only; both step by ±2. Half mode steps by ±1.
- FSM has two states, IDLE and RUN.
- IDLE with start=1 and steps≠0: latch dir, mode and speed. Load remain=steps, clear the period counter, go to RUN.
- Parity alignment on accept: if ph parity mismatches the latched mode, ph moves one half-step in dir (ph+1 if dir=1, else ph-1). This is not counted as a step.
- IDLE with start=1 and steps=0: no motion, done=1 next cycle, stay IDLE.
- RUN: the period counter counts 0..P-1. At count P-1, advance ph, decrement remain and reset the counter.
- When remain goes 1→0: go to IDLE on that edge and assert done for one cycle.
- start while RUN is ignored. dir, mode and speed changes during RUN are ignored.
- stop=1 in RUN: go to IDLE next edge. remain holds its residual value, ph does not advance, and done is not asserted. stop wins over a coincident step terminal count. stop in IDLE has no effect.
- busy=1 exactly in RUN.
- out = table[ph] when busy or HOLD=1; otherwise 4'b0000.
- Period arithmetic: use a counter width sufficient for (2^SPD_W)*BASE_DIV-1. The speed+1 term must not overflow, so compute it at SPD_W+1 bits.

## Timing
- Reset: ph=0, state IDLE, busy=0, done=0, remain=0. out=4'b1000 if HOLD=1, else 4'b0000.
- Reset asserted mid-move aborts immediately to these values, with no done pulse.
- Start accepted at edge N: busy=1 after N, and aligned out is visible after N.
- k-th step occurs at edge N+k*P, where out and remain update together.
- Final step at edge N+steps*P: busy=0 and done=1 for one cycle after that edge.
- Back-to-back moves: a start sampled in the same cycle done=1 is accepted.
- start=1 held continuously re-triggers a new move each time IDLE is reached.

## Test plan
- Reset with HOLD=1: out=1000, busy=0, done=0, remain=0. Repeat with HOLD=0: out=0000.
- BASE_DIV=4, half mode, dir=1, speed=0, steps=3 from ph=0: out 1100, 0100, 0110 at 4-cycle intervals. done pulses once with the third step, then busy=0 and remain=0.
- Full mode, dir=0, speed=1, steps=5 from ph=0: alignment to ph=7 (1001) immediately. Steps then go 0011, 0110, 1100, 1001, 0011 every 8 cycles, with correct wrap through ph 1→7.
- Wave mode, steps=4, stop asserted after step 2: busy drops next cycle, remain=2, no done, and out holds the last pattern (HOLD=1) or goes to 0000 (HOLD=0).
- start with steps=0: done for one cycle, busy stays 0, out unchanged. Second start pulse during RUN is ignored and the step count is unaffected.
- speed at maximum (all ones, SPD_W=4, BASE_DIV=4): step period is 64 cycles, with no counter overflow.
